cvxif_acc_coproc: RTL

CVXIF_ACC_COPROC -- requirements
Module: cvxif_acc_coproc

---
 rtl/cvxif_pkg.sv | 123 ++++++++++++
 rtl/cvxif_acc_coproc_if.sv | 10 +
 rtl/cvxif_acc_decoder.sv | 52 +++++
 rtl/cvxif_acc_coproc.sv | 113 +++++++++++
 4 files changed

// File: rtl/cvxif_pkg.sv
// CV-X-IF channel typedefs plus the accelerator's op encodings and result-buffer entry.
package cvxif_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned X_NUM_RS    = 2;
  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_MEM_WIDTH = 32;

  localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
  localparam logic [6:0] F7_ALU  = 7'd0;
  localparam logic [6:0] F7_CNOP = 7'd2;
  localparam logic [2:0] F3_CADD = 3'd0;
  localparam logic [2:0] F3_CSUB = 3'd1;
  localparam logic [2:0] F3_CXOR = 3'd2;
  localparam logic [2:0] F3_CNOP = 3'd0;

  typedef logic [X_ID_WIDTH-1:0] id_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [1:0]  mode;
    id_t         id;
  } x_compressed_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } x_compressed_resp_t;

  typedef struct packed {
    logic [31:0]                          instr;
    logic [1:0]                           mode;
    id_t                                  id;
    logic [X_NUM_RS-1:0][XLEN-1:0]        rs;
    logic [X_NUM_RS-1:0]                  rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    id_t  id;
    logic commit_kill;
  } x_commit_t;

  typedef struct packed {
    id_t                    id;
    logic [31:0]            addr;
    logic [1:0]             mode;
    logic                   we;
    logic [1:0]             size;
    logic [X_MEM_WIDTH/8-1:0] be;
    logic [1:0]             attr;
    logic [X_MEM_WIDTH-1:0] wdata;
    logic                   last;
    logic                   spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    id_t                    id;
    logic [X_MEM_WIDTH-1:0] rdata;
    logic                   err;
    logic                   dbg;
  } x_mem_result_t;

  typedef struct packed {
    id_t        id;
    xlen_t      data;
    logic [4:0] rd;
    logic       we;
    logic       exc;
    logic [5:0] exccode;
  } x_result_t;

  typedef struct packed {
    logic              x_compressed_valid;
    x_compressed_req_t x_compressed_req;
    logic              x_issue_valid;
    x_issue_req_t      x_issue_req;
    logic              x_commit_valid;
    x_commit_t         x_commit;
    logic              x_mem_ready;
    x_mem_resp_t       x_mem_resp;
    logic              x_mem_result_valid;
    x_mem_result_t     x_mem_result;
    logic              x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic               x_compressed_ready;
    x_compressed_resp_t x_compressed_resp;
    logic               x_issue_ready;
    x_issue_resp_t      x_issue_resp;
    logic               x_mem_valid;
    x_mem_req_t         x_mem_req;
    logic               x_result_valid;
    x_result_t          x_result;
  } cvxif_resp_t;

  typedef struct packed {
    logic       valid;
    id_t        id;
    logic [4:0] rd;
    xlen_t      data;
    logic       we;
    logic       committed;
    logic       killed;
  } acc_entry_t;

endpackage

// File: rtl/cvxif_acc_coproc_if.sv
// Bundles the CV-X-IF request/response structs between a core and the accelerator.
interface cvxif_acc_coproc_if;
  import cvxif_pkg::*;

  cvxif_req_t  req;
  cvxif_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/cvxif_acc_decoder.sv
// Combinational decode and ALU for the CUSTOM3 accelerator ops.
module cvxif_acc_decoder
  import cvxif_pkg::*;
(
  input  logic [31:0]                   i_instr,
  input  logic [X_NUM_RS-1:0][XLEN-1:0] i_rs,
  output logic                          o_recognised,
  output logic                          o_writeback,
  output logic [XLEN-1:0]               o_data
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  logic       w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_funct7 = i_instr[31:25];
  assign w_funct3 = i_instr[14:12];
  assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    o_recognised = 1'b0;
    o_writeback  = 1'b0;
    o_data       = '0;
    if (w_opcode == OPCODE_CUSTOM3) begin
      if (w_funct7 == F7_ALU) begin
        case (w_funct3)
          F3_CADD: begin
            o_recognised = 1'b1;
            o_writeback  = 1'b1;
            o_data       = i_rs[0] + i_rs[1];
          end
          F3_CSUB: begin
            o_recognised = 1'b1;
            o_writeback  = 1'b1;
            o_data       = i_rs[0] - i_rs[1];
          end
          F3_CXOR: begin
            o_recognised = 1'b1;
            o_writeback  = 1'b1;
            o_data       = i_rs[0] ^ i_rs[1];
          end
          default: ;
        endcase
      end else if (w_funct7 == F7_CNOP && w_funct3 == F3_CNOP) begin
        o_recognised = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cvxif_acc_coproc.sv
// CV-X-IF accelerator: issues CUSTOM3 ALU ops into an in-order result buffer,
// tracks commit/kill per entry, and returns committed results in issue order.
module cvxif_acc_coproc
  import cvxif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  cvxif_req_t  cvxif_req_i,
  output cvxif_resp_t cvxif_resp_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  acc_entry_t       r_buf [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic        w_recognised;
  logic        w_writeback;
  xlen_t       w_data;
  logic        w_issue_ready;
  logic        w_push;
  logic        w_pop;
  logic        w_result_valid;
  acc_entry_t  w_head;
  acc_entry_t  w_new_entry;
  logic        w_unused;

  cvxif_acc_decoder u_decoder (
    .i_instr      (cvxif_req_i.x_issue_req.instr),
    .i_rs         (cvxif_req_i.x_issue_req.rs),
    .o_recognised (w_recognised),
    .o_writeback  (w_writeback),
    .o_data       (w_data)
  );

  // Unrecognised instructions are always acknowledged (and rejected) so the core never stalls on them.
  assign w_issue_ready = !w_recognised ||
                         ((r_count < CNT_W'(DEPTH)) && (cvxif_req_i.x_issue_req.rs_valid[1:0] == 2'b11));
  assign w_push = cvxif_req_i.x_issue_valid && w_issue_ready && w_recognised;

  assign w_head         = r_buf[r_head];
  assign w_result_valid = w_head.valid && w_head.committed && !w_head.killed;
  // A killed head leaves without a handshake so it never blocks younger results.
  assign w_pop = (w_result_valid && cvxif_req_i.x_result_ready) ||
                 (w_head.valid && w_head.committed && w_head.killed);

  always_comb begin
    w_new_entry           = '0;
    w_new_entry.valid     = 1'b1;
    w_new_entry.id        = cvxif_req_i.x_issue_req.id;
    w_new_entry.rd        = cvxif_req_i.x_issue_req.instr[11:7];
    w_new_entry.data      = w_data;
    w_new_entry.we        = w_writeback;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (cvxif_req_i.x_commit_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_buf[i].valid && (r_buf[i].id == cvxif_req_i.x_commit.id)) begin
            r_buf[i].committed <= 1'b1;
            r_buf[i].killed    <= cvxif_req_i.x_commit.commit_kill;
          end
        end
      end
      // Push and pop never target the same slot: push needs count<DEPTH, pop needs count>0.
      if (w_push) begin
        r_buf[r_tail] <= w_new_entry;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_buf[r_head].valid <= 1'b0;
        r_head              <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    cvxif_resp_o                        = '0;
    cvxif_resp_o.x_compressed_ready     = 1'b1;
    cvxif_resp_o.x_issue_ready          = w_issue_ready;
    cvxif_resp_o.x_issue_resp.accept    = w_recognised;
    cvxif_resp_o.x_issue_resp.writeback = w_writeback;
    cvxif_resp_o.x_result_valid         = w_result_valid;
    cvxif_resp_o.x_result.id            = w_head.id;
    cvxif_resp_o.x_result.data          = w_head.data;
    cvxif_resp_o.x_result.rd            = w_head.rd;
    cvxif_resp_o.x_result.we            = w_head.we;
  end

  assign w_unused = ^{cvxif_req_i.x_compressed_valid, cvxif_req_i.x_compressed_req,
                      cvxif_req_i.x_issue_req.mode, cvxif_req_i.x_mem_ready,
                      cvxif_req_i.x_mem_resp, cvxif_req_i.x_mem_result_valid,
                      cvxif_req_i.x_mem_result};

endmodule
